// File: rtl/minhash_topk_sorter_pkg.sv
// Shared types and defaults for the MinHash top-k sorter.
// The sorter keeps the smallest signatures of a fragment and drains them in ascending order.
package minhash_topk_sorter_pkg;

  localparam int SORTER_DEPTH = 4;
  localparam bit SORTER_DEDUP = 1'b1;
  localparam int SORTER_SIG_W = 32;
  localparam int SORTER_IDX_W = 5;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } sorter_state_e;

  typedef struct packed {
    logic [SORTER_SIG_W-1:0] sig;
    logic [SORTER_IDX_W-1:0] idx;
  } signature_index_pack;

endpackage

// File: rtl/minhash_topk_sorter_cell.sv
// One slot of the insertion-sort table: holds a (sig, idx) pair and reports how it
// compares against the signature currently offered on the input.
module minhash_topk_sorter_cell
  import minhash_topk_sorter_pkg::*;
#(
  parameter int SIG_W = SORTER_SIG_W,
  parameter int IDX_W = SORTER_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load_new,
  input  logic             i_shift,
  input  logic [SIG_W-1:0] i_in_sig,
  input  logic [IDX_W-1:0] i_in_idx,
  input  logic             i_up_valid,
  input  logic [SIG_W-1:0] i_up_sig,
  input  logic [IDX_W-1:0] i_up_idx,
  output logic             o_valid,
  output logic [SIG_W-1:0] o_sig,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_gt,
  output logic             o_eq
);

  logic             r_valid;
  logic [SIG_W-1:0] r_sig;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load_new) begin
      r_valid <= 1'b1;
    end else if (i_shift) begin
      r_valid <= i_up_valid;
    end
  end

  // Payload is never reset; r_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (i_load_new) begin
      r_sig <= i_in_sig;
      r_idx <= i_in_idx;
    end else if (i_shift) begin
      r_sig <= i_up_sig;
      r_idx <= i_up_idx;
    end
  end

  assign o_valid = r_valid;
  assign o_sig   = r_sig;
  assign o_idx   = r_idx;
  assign o_gt    = r_valid && (r_sig > i_in_sig);
  assign o_eq    = r_valid && (r_sig == i_in_sig);

endmodule

// File: rtl/minhash_topk_sorter.sv
// Streaming top-k sorter: inserts one pair per cycle while filling, then drains the
// kept entries in ascending signature order over a ready/valid stream.
module minhash_topk_sorter
  import minhash_topk_sorter_pkg::*;
#(
  parameter int SIG_W = SORTER_SIG_W,
  parameter int IDX_W = SORTER_IDX_W,
  parameter int DEPTH = SORTER_DEPTH,
  parameter bit DEDUP = SORTER_DEDUP,
  parameter int POS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [IDX_W-1:0] out_idx,
  output logic [POS_W-1:0] out_pos,
  output logic             out_last
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  sorter_state_e    r_state;
  sorter_state_e    w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_rd;

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_gt;
  logic [DEPTH-1:0] w_eq;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_thru;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_shift;
  logic [SIG_W-1:0] w_sig [DEPTH];
  logic [IDX_W-1:0] w_idx [DEPTH];

  logic w_in_acc;
  logic w_out_hs;
  logic w_dup;
  logic w_do_ins;
  logic w_clear;

  // A slot is a candidate when it holds a larger signature or is empty; entries stay
  // packed at the front, so the first candidate is the insert point.
  assign w_sel = w_gt | ~w_valid;

  always_comb begin
    w_thru    = '0;
    w_thru[0] = w_sel[0];
    for (int i = 1; i < DEPTH; i++) begin
      w_thru[i] = w_thru[i-1] | w_sel[i];
    end
  end

  assign w_in_acc = in_valid && in_ready;
  assign w_dup    = DEDUP && (|w_eq);
  assign w_do_ins = w_in_acc && !w_dup && w_thru[DEPTH-1];
  assign w_out_hs = out_valid && out_ready;
  assign w_clear  = w_out_hs && out_last;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign w_load[g]  = w_do_ins && w_thru[g];
      assign w_shift[g] = 1'b0;

      minhash_topk_sorter_cell #(.SIG_W(SIG_W), .IDX_W(IDX_W)) u_cell (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_load_new (w_load[g]),
        .i_shift    (w_shift[g]),
        .i_in_sig   (in_sig),
        .i_in_idx   (in_idx),
        .i_up_valid (1'b0),
        .i_up_sig   ('0),
        .i_up_idx   ('0),
        .o_valid    (w_valid[g]),
        .o_sig      (w_sig[g]),
        .o_idx      (w_idx[g]),
        .o_gt       (w_gt[g]),
        .o_eq       (w_eq[g])
      );
    end else begin : g_body
      assign w_load[g]  = w_do_ins && w_thru[g] && !w_thru[g-1];
      assign w_shift[g] = w_do_ins && w_thru[g-1];

      minhash_topk_sorter_cell #(.SIG_W(SIG_W), .IDX_W(IDX_W)) u_cell (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_load_new (w_load[g]),
        .i_shift    (w_shift[g]),
        .i_in_sig   (in_sig),
        .i_in_idx   (in_idx),
        .i_up_valid (w_valid[g-1]),
        .i_up_sig   (w_sig[g-1]),
        .i_up_idx   (w_idx[g-1]),
        .o_valid    (w_valid[g]),
        .o_sig      (w_sig[g]),
        .o_idx      (w_idx[g]),
        .o_gt       (w_gt[g]),
        .o_eq       (w_eq[g])
      );
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_sig     = '0;
    out_idx     = '0;
    out_pos     = '0;
    out_last    = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_pos   = r_rd[POS_W-1:0];
        out_last  = (r_rd == (r_count - CNT_W'(1)));
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd == CNT_W'(i)) begin
            out_sig = w_sig[i];
            out_idx = w_idx[i];
          end
        end
        if (out_ready && out_last) w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_count <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_count <= '0;
        r_rd    <= '0;
      end else begin
        if (w_do_ins && (r_count != CNT_W'(DEPTH))) r_count <= r_count + CNT_W'(1);
        if (w_out_hs) r_rd <= r_rd + CNT_W'(1);
      end
    end
  end

endmodule
